// File: rtl/spi_slave_if.sv
// SPI pin bundle between an SPI master and the spi_slave responder.
interface spi_slave_if;
  logic SCLK;
  logic SS;
  logic MOSI;
  logic MISO;

  modport master (output SCLK, output SS, output MOSI, input MISO);
  modport slave  (input SCLK, input SS, input MOSI, output MISO);
endinterface

// File: rtl/spi_slave.sv
// Oversampling SPI responder, all four CPOL/CPHA modes, back-to-back bytes while SS stays low.
// Optional feature macro: SPI_SLAVE_OVERRUN_EN (adds rx_ack/overrun receive-overrun tracking).
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic [7:0]  tx_data,
  output logic        tx_load,
  output logic [7:0]  rx_data,
  output logic        done,
  output logic        busy,
`ifdef SPI_SLAVE_OVERRUN_EN
  input  logic        rx_ack,
  output logic        overrun,
`endif
  spi_slave_if.slave  spi
);

  typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   ss_hist_q, ss_hist_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   done_q, done_d;
  logic                   reload_pend_q, reload_pend_d;
  logic                   lead_seen_q, lead_seen_d;
  logic                   sclk_sync, ss_sync, mosi_sync;
  logic                   sck_now, sck_prev, lead_edge, trail_edge;
  logic                   sample_edge, shift_edge, ss_fall;
  logic                   complete, reload_now;

  always_comb begin
    sclk_sync   = sclk_sync_q[SYNC_STAGES-1];
    ss_sync     = ss_sync_q[SYNC_STAGES-1];
    mosi_sync   = mosi_sync_q[SYNC_STAGES-1];
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi.SS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
    sclk_hist_d = sclk_sync;
    ss_hist_d   = ss_sync;
    // Normalising by CPOL makes "leading" always a 0->1 transition.
    sck_now     = sclk_sync ^ CPOL;
    sck_prev    = sclk_hist_q ^ CPOL;
    lead_edge   = sck_now & ~sck_prev;
    trail_edge  = ~sck_now & sck_prev;
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    ss_fall     = ss_hist_q & ~ss_sync;
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_data_d     = rx_data_q;
    done_d        = 1'b0;
    reload_pend_d = reload_pend_q;
    lead_seen_d   = lead_seen_q;
    complete      = 1'b0;
    reload_now    = 1'b0;
    tx_load       = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d     = 3'd0;
        rx_shift_d    = 7'd0;
        tx_shift_d    = 8'd0;
        reload_pend_d = 1'b0;
        lead_seen_d   = 1'b0;
        if (ss_fall) state_d = LOAD;
      end
      LOAD: begin
        tx_shift_d = tx_data;
        tx_load    = 1'b1;
        state_d    = XFER;
      end
      XFER: begin
        if (sample_edge) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_sync};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            complete      = 1'b1;
            rx_data_d     = {rx_shift_q, mosi_sync};
            done_d        = 1'b1;
            reload_pend_d = 1'b1;
            lead_seen_d   = 1'b0;
          end
        end
        if (shift_edge) begin
          // With CPHA=1 bit 7 is already on MISO, so the first leading edge only reloads (bytes 2..n).
          if (!CPHA) begin
            if (reload_pend_q) reload_now = 1'b1;
            else               tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end else if (!lead_seen_q) begin
            lead_seen_d = 1'b1;
            reload_now  = reload_pend_q;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
        if (reload_now) begin
          tx_shift_d    = tx_data;
          reload_pend_d = 1'b0;
          tx_load       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // SS deselect aborts any partial byte; rx_data keeps the last complete one.
    if (ss_sync && state_q != IDLE) begin
      state_d       = IDLE;
      bit_cnt_d     = 3'd0;
      rx_shift_d    = 7'd0;
      tx_shift_d    = 8'd0;
      rx_data_d     = rx_data_q;
      done_d        = 1'b0;
      reload_pend_d = 1'b0;
      lead_seen_d   = 1'b0;
      complete      = 1'b0;
      tx_load       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sclk_sync_q   <= {SYNC_STAGES{CPOL}};
      ss_sync_q     <= {SYNC_STAGES{1'b1}};
      mosi_sync_q   <= '0;
      sclk_hist_q   <= CPOL;
      ss_hist_q     <= 1'b1;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 7'd0;
      tx_shift_q    <= 8'd0;
      rx_data_q     <= 8'd0;
      done_q        <= 1'b0;
      reload_pend_q <= 1'b0;
      lead_seen_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_hist_q   <= sclk_hist_d;
      ss_hist_q     <= ss_hist_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_data_q     <= rx_data_d;
      done_q        <= done_d;
      reload_pend_q <= reload_pend_d;
      lead_seen_q   <= lead_seen_d;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_valid_q, rx_valid_d;
  logic overrun_q, overrun_d;

  // A completion in the same cycle as rx_ack wins: the new byte stays valid, no overrun.
  always_comb begin
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (complete) begin
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
    if (rx_ack) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  logic unused_complete;
  assign unused_complete = complete;
`endif

  assign rx_data  = rx_data_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign spi.MISO = busy ? tx_shift_q[7] : 1'b0;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: behavioural SPI master plus rx/MISO scoreboard queues.
module tb_spi_slave;
  localparam int HP   = 50;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpol, cpha;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       done;
  logic       busy;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_ack;
  logic       overrun;
`endif

  spi_slave_if bus();

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst     (rst),
    .CPOL    (cpol),
    .CPHA    (cpha),
    .tx_data (tx_data),
    .tx_load (tx_load),
    .rx_data (rx_data),
    .done    (done),
    .busy    (busy),
`ifdef SPI_SLAVE_OVERRUN_EN
    .rx_ack  (rx_ack),
    .overrun (overrun),
`endif
    .spi     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tx_load_cnt = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] miso_exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Receive-side scoreboard: each done pops the byte the master sent.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (rx_exp_q.size() > 0) check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
        else                     check("done_unexpected", {31'd0, done}, 32'd0);
      end
      if (tx_load) tx_load_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol     = p;
    cpha     = h;
    bus.SCLK = p;
    wait_clk(10);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_miso", {31'd0, bus.MISO}, 32'd0);
  endtask

  task automatic set_tx(input logic [7:0] b);
    tx_data = b;
    miso_exp_q.push_back(b);
  endtask

  task automatic ss_begin();
    bus.SS = 1'b0;
    wait_clk(HP);
  endtask

  task automatic ss_end();
    wait_clk(HP);
    bus.SS = 1'b1;
    wait_clk(HP);
    check("pending_rx", rx_exp_q.size(), 32'd0);
  endtask

  task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'd0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha) begin
        bus.MOSI = mo[i];
        wait_clk(HP);
        bus.SCLK = ~cpol;
        mi = {mi[6:0], bus.MISO};
        wait_clk(HP);
        bus.SCLK = cpol;
      end else begin
        bus.SCLK = ~cpol;
        bus.MOSI = mo[i];
        wait_clk(HP);
        bus.SCLK = cpol;
        mi = {mi[6:0], bus.MISO};
        wait_clk(HP);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] mo);
    logic [7:0] mi;
    rx_exp_q.push_back(mo);
    xfer_bits(mo, 8, mi);
    if (miso_exp_q.size() > 0) check("master_rx", {24'd0, mi}, {24'd0, miso_exp_q.pop_front()});
    else                       check("master_rx_unscheduled", {24'd0, mi}, 32'hFFFF_FFFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi;
    int cyc;
    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; tx_data = 8'h00;
    bus.SCLK = 1'b0; bus.SS = 1'b1; bus.MOSI = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    rx_ack = 1'b0;
`endif
    wait_clk(5);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_tx_load", {31'd0, tx_load}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_miso", {31'd0, bus.MISO}, 32'd0);
    rst = 1'b0;

    // Mode 0 single byte
    set_mode(1'b0, 1'b0);
    set_tx(8'h3C);
    ss_begin();
    check("busy_active", {31'd0, busy}, 32'd1);
    send_byte(8'hA5);
    ss_end();

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      set_tx(8'h69);
      ss_begin();
      send_byte(8'h96);
      ss_end();
    end

    // Two bytes with SS held low (mode 1)
    set_mode(1'b0, 1'b1);
    tx_load_cnt = 0;
    set_tx(8'h3C);
    ss_begin();
    send_byte(8'h01);
    set_tx(8'hF0);
    send_byte(8'h80);
    ss_end();
    check("tx_load_count", tx_load_cnt, 32'd2);

    // SS raised after 5 bits (mode 0)
    set_mode(1'b0, 1'b0);
    tx_data = 8'h77;
    ss_begin();
    xfer_bits(8'hFF, 5, mi);
    bus.SS = 1'b1;
    cyc = 0;
    while (busy && cyc < SYNC + 2) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_busy", {31'd0, busy}, 32'd0);
    wait_clk(HP);
    check("abort_rx_kept", {24'd0, rx_data}, 32'h80);
    set_tx(8'h3C);
    ss_begin();
    send_byte(8'h5A);
    ss_end();

    // rst pulsed mid-byte
    tx_data = 8'h55;
    ss_begin();
    xfer_bits(8'h0F, 3, mi);
    rst = 1'b1;
    bus.SS = 1'b1;
    bus.SCLK = cpol;
    @(negedge clk);
    rst = 1'b0;
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tx_load", {31'd0, tx_load}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_miso", {31'd0, bus.MISO}, 32'd0);
    wait_clk(HP);
    set_tx(8'h3C);
    ss_begin();
    send_byte(8'hC3);
    ss_end();

`ifdef SPI_SLAVE_OVERRUN_EN
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
    check("overrun_cleared", {31'd0, overrun}, 32'd0);
    set_tx(8'hAA);
    ss_begin();
    send_byte(8'h11);
    ss_end();
    check("overrun_first", {31'd0, overrun}, 32'd0);
    set_tx(8'hBB);
    ss_begin();
    send_byte(8'h22);
    ss_end();
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("overrun_rx_data", {24'd0, rx_data}, 32'h22);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
    check("overrun_ack", {31'd0, overrun}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave (responder) for the SPI peripheral subsystem: the far end of the SPI master on the same bus. It oversamples external SCLK/SS/MOSI with the system clock and supports all four CPOL/CPHA modes. It delivers each received byte as `rx_data` with a one-cycle `done` pulse, and shifts out a byte taken from `tx_data` on MISO. Used for loopback verification of the master and as a peripheral-side endpoint behind the AXI-Lite wrapper.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on SCLK, SS, MOSI (legal 2..3).
- `clk`  input  1  system clock; must be ≥8× SCLK frequency (SCLK half-period ≥4 `clk` cycles).
- `rst`  input  1  reset; one clock, reset is synchronous and active-high.
- `CPOL`  input  1  SCLK idle level; static while SS is low.
- `CPHA`  input  1  0: sample on leading edge; 1: sample on trailing edge. Static while SS is low.
- `tx_data`  input  8  next byte to transmit; captured on `tx_load`.
- `tx_load`  output  1  one-cycle pulse: `tx_data` captured into the TX shift register.
- `rx_data`  output  8  last complete received byte, MSB first; held until the next `done`.
- `done`  output  1  one-cycle pulse: `rx_data` updated.
- `busy`  output  1  high while the synchronized SS is low.
- `SCLK`  input  1  external serial clock (asynchronous).
- `SS`  input  1  external slave select, active-low (asynchronous).
- `MOSI`  input  1  external data in (asynchronous).
- `MISO`  output  1  external data out.

## Operation
- SCLK, SS and MOSI each pass through a `SYNC_STAGES` flop chain, followed by one history flop for edge detection.
- Normalized clock `sck_n = sclk_sync ^ CPOL`.
  - Leading edge: `sck_n` 0→1. Trailing edge: `sck_n` 1→0.
- Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge is the other one.
- States:
  - IDLE: SS high. `bit_cnt`=0, `MISO`=0, `busy`=0.
  - LOAD: one cycle, entered on the SS falling edge. Captures `tx_data`, pulses `tx_load`, then goes to XFER.
  - XFER: on a sample edge, `rx_shift <= {rx_shift[6:0], MOSI_sync}` and `bit_cnt`++.
- 8th sample edge:
  - Next cycle: `rx_data <= rx_shift` (including the 8th bit) and `done`=1.
  - `bit_cnt` wraps to 0.
- Shift edge:
  - CPHA=0: `tx_shift <= {tx_shift[6:0],0}`. On the shift edge following the 8th sample, reload from `tx_data` instead and pulse `tx_load` (back-to-back bytes while SS stays low).
  - CPHA=1: the first leading edge of each byte does not shift, because bit 7 is already on MISO. On later leading edges, shift. The first leading edge of bytes 2..n reloads `tx_data` and pulses `tx_load`.
- `MISO = tx_shift[7]` while `busy`; 0 otherwise.
- SS rising at any time (including mid-byte) → IDLE next cycle:
  - partial byte discarded, no `done`;
  - `bit_cnt`, `rx_shift` and `tx_shift` cleared;
  - `rx_data` retained.
- SCLK edges while SS is high are ignored.

## Timing
- Reset values: `rx_data`=0x00, `done`=0, `tx_load`=0, `busy`=0, `MISO`=0, state IDLE. All synchronizer and history flops are reset to their idle values: SS=1, SCLK=CPOL.
- Pin-to-internal edge detection latency: `SYNC_STAGES`+1 cycles (3 at default).
- Pin SS fall → `tx_load` pulse: `SYNC_STAGES`+1 cycles. MISO valid 1 cycle after `tx_load`.
- Setup requirement: SS low → first SCLK edge ≥ `SYNC_STAGES`+3 `clk` cycles. The master's 50-cycle half-period satisfies this.
- `done` pulse: 1 cycle after the 8th sample edge is detected. `rx_data` is stable from that cycle.
- `tx_data` must be stable from the previous `done` (or SS fall) through `tx_load`.
- `rst` asserted mid-transfer: all state returns to reset values on the next `clk` edge; no `done` is generated.

## Configuration
- `SPI_SLAVE_OVERRUN_EN`: when defined, adds input `rx_ack` (1 bit) and output `overrun` (1 bit, reset 0).
  - `done` still pulses, and an internal `rx_valid` flag is set.
  - `rx_ack`=1 clears `rx_valid`.
  - A new byte completing while `rx_valid`=1 sets sticky `overrun` and still updates `rx_data`. `overrun` clears only on `rx_ack` or `rst`.
  - If completion and `rx_ack` fall in the same cycle, completion wins: `rx_valid` stays 1 and `overrun` is not set.
- Undefined: no extra ports, no flag logic.

## Test plan
- Mode 0 (CPOL=0, CPHA=0), master at 50-cycle half-period: master sends 0xA5, `tx_data`=0x3C → slave `rx_data`=0xA5, one `done` pulse, master receives 0x3C.
- Modes 1, 2 and 3 each: master 0x96 / slave 0x69 → both sides receive correctly. SCLK idles at CPOL while SS is high.
- Two bytes with SS held low: master 0x01, 0x80; slave `tx_data` changed to 0xF0 after the first `done` → `rx_data` 0x01 then 0x80, two `done` pulses, two `tx_load` pulses, master receives 0x3C then 0xF0.
- SS raised after 5 bits → no `done`, `rx_data` keeps its prior value, `busy`=0 within `SYNC_STAGES`+2 cycles. The next full byte 0x5A is received correctly.
- `rst` pulsed mid-byte → all outputs at reset values the following cycle. The next transfer of 0xC3 completes correctly.
- With `SPI_SLAVE_OVERRUN_EN`: two bytes received without `rx_ack` → `overrun`=1, `rx_data`=second byte. `rx_ack` pulse → `overrun`=0.
